// File: rtl/ram_frame_reader_if.sv
// +----------------------------------------------------------------------------+
// | ram_frame_reader_if                                                        |
// | Word read port (from ping-pong buffer) and byte stream port (to UART).     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

interface ram_frame_reader_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] read_data_i;
  logic             read_valid_i;
  logic             read_ready_o;
  logic [7:0]       byte_data_o;
  logic             byte_valid_o;
  logic             byte_ready_i;

  // slave: the frame reader itself
  modport slave (
    input  read_data_i, read_valid_i, byte_ready_i,
    output read_ready_o, byte_data_o, byte_valid_o
  );

  // master: the buffer read port plus the byte transmitter
  modport master (
    output read_data_i, read_valid_i, byte_ready_i,
    input  read_ready_o, byte_data_o, byte_valid_o
  );
endinterface

`default_nettype wire

// File: rtl/ram_frame_reader.sv
// +----------------------------------------------------------------------------+
// | ram_frame_reader                                                           |
// | Drains DEPTH words per buffer-ready pulse into a framed, checksummed byte  |
// | stream: SYNC, SEQ, payload (MSB first), XOR checksum.                      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module ram_frame_reader #(
  parameter int         WIDTH     = 32,
  parameter int         DEPTH     = 256,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  wire logic         clk_i,
  input  wire logic         rst_i,
  input  wire logic         buffer_ready_i,
  ram_frame_reader_if.slave bus,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              frame_dropped_o,
  output logic [7:0]        frame_seq_o
);

  localparam int                   BYTES    = WIDTH / 8;
  localparam int                   IDX_W    = 2;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(BYTES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SYNC  = 3'd1,
    S_SEQ   = 3'd2,
    S_FETCH = 3'd3,
    S_SEND  = 3'd4,
    S_CSUM  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [WIDTH-1:0]     shift_q, shift_d;
  logic [7:0]           csum_q, csum_d;
  logic [7:0]           seq_q, seq_d;
  logic [7:0]           byte_data_q, byte_data_d;
  logic                 byte_valid_q, byte_valid_d;
  logic                 read_ready_q, read_ready_d;
  logic                 done_q, done_d;
  logic                 drop_q, drop_d;

  logic byte_fire;
  logic word_fire;

  assign byte_fire = byte_valid_q && bus.byte_ready_i;
  assign word_fire = read_ready_q && bus.read_valid_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    csum_d  = csum_q;
    seq_d   = seq_q;
    done_d  = 1'b0;
    drop_d  = buffer_ready_i && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (buffer_ready_i) begin
          state_d = S_SYNC;
          csum_d  = 8'h00;
          cnt_d   = '0;
        end
      end
      S_SYNC: begin
        if (byte_fire) state_d = S_SEQ;
      end
      S_SEQ: begin
        if (byte_fire) begin
          csum_d  = csum_q ^ seq_q;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (word_fire) begin
          shift_d = bus.read_data_i;
          idx_d   = LAST_IDX;
          cnt_d   = cnt_q + 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (byte_fire) begin
          csum_d  = csum_q ^ byte_data_q;
          shift_d = shift_q << 8;
          if (idx_q == '0) begin
            state_d = (cnt_q == CNT_MAX) ? S_CSUM : S_FETCH;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
      end
      S_CSUM: begin
        if (byte_fire) begin
          done_d  = 1'b1;
          seq_d   = seq_q + 8'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they leave flops directly.
    read_ready_d = (state_d == S_FETCH);
    byte_valid_d = (state_d == S_SYNC) || (state_d == S_SEQ) ||
                   (state_d == S_SEND) || (state_d == S_CSUM);
    case (state_d)
      S_SYNC:  byte_data_d = SYNC_BYTE;
      S_SEQ:   byte_data_d = seq_d;
      S_SEND:  byte_data_d = shift_d[WIDTH-1 -: 8];
      S_CSUM:  byte_data_d = csum_d;
      default: byte_data_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      csum_q       <= 8'h00;
      seq_q        <= 8'h00;
      byte_data_q  <= 8'h00;
      byte_valid_q <= 1'b0;
      read_ready_q <= 1'b0;
      done_q       <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      csum_q       <= csum_d;
      seq_q        <= seq_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      read_ready_q <= read_ready_d;
      done_q       <= done_d;
      drop_q       <= drop_d;
    end
  end

  assign bus.read_ready_o = read_ready_q;
  assign bus.byte_data_o  = byte_data_q;
  assign bus.byte_valid_o = byte_valid_q;
  assign busy_o           = (state_q != S_IDLE);
  assign frame_done_o     = done_q;
  assign frame_dropped_o  = drop_q;
  assign frame_seq_o      = seq_q;

endmodule

`default_nettype wire

// File: doc/ram_frame_reader.md
Name: ram_frame_reader

Overview:
Drains one full ping-pong buffer per frame from the RAM controller's read port. It starts on the controller's buffer-ready pulse and accepts exactly DEPTH words over a ready/valid handshake. Each word is serialised MSB-first into a framed byte stream (sync byte, sequence number, payload, XOR checksum) for the UART/host link. It sits between the ping-pong buffer and the byte-level transmitter.

Parameters:
WIDTH, 32, sample width in bits; legal values are 8, 16 and 32.
DEPTH, 256, words per frame; must equal the buffer depth of the upstream controller.
SYNC_BYTE, 8'hA5, first byte of every frame.
CNT_WIDTH, $clog2(DEPTH)+1, width of the word counter.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, synchronous, active-high
buffer_ready_i  in  1  one-cycle pulse: a full buffer is available to read
read_data_i  in  WIDTH  word from the buffer read port
read_valid_i  in  1  read_data_i is valid
read_ready_o  out  1  reader accepts a word this cycle
byte_data_o  out  8  serial byte
byte_valid_o  out  1  byte_data_o is valid
byte_ready_i  in  1  downstream accepts the byte
busy_o  out  1  a frame is in progress (state is not IDLE)
frame_done_o  out  1  one-cycle pulse after the checksum byte is accepted
frame_dropped_o  out  1  one-cycle pulse: buffer_ready_i arrived while busy
frame_seq_o  out  8  sequence number of the current or next frame

Behaviour:
- One clock; reset is synchronous and active-high (rst_i). Reset takes priority over every other event, including mid-frame.
- Reset values: state IDLE; read_ready_o 0, byte_valid_o 0, byte_data_o 8'h00, busy_o 0, frame_done_o 0, frame_dropped_o 0, frame_seq_o 0. Word counter, byte index, shift register and checksum are all 0.
- Handshakes:
  - A word transfers on read_valid_i && read_ready_o.
  - A byte transfers on byte_valid_o && byte_ready_i.
  - byte_data_o and byte_valid_o are driven from registers only, with no combinational path from byte_ready_i.
  - While byte_valid_o is 1 and the byte has not been accepted, byte_data_o stays stable.
- FSM states: IDLE, SYNC, SEQ, FETCH, SEND, CSUM.
- IDLE:
  - On buffer_ready_i: go to SYNC and clear the checksum and the word counter.
  - Latency is 1 cycle: byte_valid_o=1 with SYNC_BYTE in the cycle after the pulse.
- SYNC: present SYNC_BYTE; on accept go to SEQ. SYNC_BYTE is excluded from the checksum.
- SEQ: present frame_seq_o; on accept, checksum ^= seq, then go to FETCH.
- FETCH:
  - read_ready_o=1 and byte_valid_o=0.
  - On a word transfer: load the shift register, set byte index = WIDTH/8-1, increment the word counter, go to SEND.
  - If read_valid_i is low, wait indefinitely.
- SEND:
  - Present shift[WIDTH-1:WIDTH-8].
  - On accept: checksum ^= byte, shift left by 8, decrement the byte index.
  - After the last byte: if word counter == DEPTH go to CSUM, else go to FETCH.
- CSUM: present the checksum; on accept, pulse frame_done_o, increment frame_seq_o (wraps 255->0), go to IDLE.
- Throughput: with byte_ready_i held at 1, one word takes WIDTH/8+1 cycles. The full frame takes 2 + DEPTH*(WIDTH/8+1) + 1 cycles from SYNC to the end of CSUM.
- read_ready_o is 0 in every state except FETCH. Words offered outside FETCH are not consumed.
- Dropped frames: buffer_ready_i in any state other than IDLE is ignored. frame_dropped_o pulses on the following cycle. The current frame continues unaffected and frame_seq_o does not change.
- Simultaneous events: buffer_ready_i in the same cycle as the CSUM accept counts as a drop. The FSM returns to IDLE and does not restart.
- Word count: the reader consumes exactly DEPTH words per frame, which matches the upstream release of read_in_progress after DEPTH reads. It never requests word DEPTH+1.
- busy_o = (state != IDLE).

Test Plan:
- Basic frame (WIDTH=16, DEPTH=4, byte_ready_i=1): pulse buffer_ready_i, offer words 1234,5678,9ABC,DEF1 -> byte stream A5,00,12,34,56,78,9A,BC,DE,F1,01. frame_done_o pulses once, then frame_seq_o=1.
- Back-to-back frames: repeat the same data for a second frame -> stream A5,01,...,DE,F1,00 with checksum 00, and frame_seq_o=2 afterwards. Run 256 frames -> the sequence byte wraps to 00.
- Backpressure: toggle byte_ready_i randomly and stall read_valid_i for 5 cycles in FETCH -> identical byte sequence. byte_data_o is stable while valid is high and not ready. read_ready_o is 0 during SEND.
- Drop: pulse buffer_ready_i mid-frame at word 2 -> frame_dropped_o pulses one cycle later, the current frame completes intact, and no second frame starts.
- Reset mid-frame: assert rst_i during SEND of word 3 -> next cycle all outputs are at reset values and frame_seq_o=0. A new buffer_ready_i starts a clean frame beginning with A5,00.
- Latency: buffer_ready_i at cycle N -> byte_valid_o=1 with A5 at N+1. With byte_ready_i=1 the full DEPTH=4, WIDTH=16 frame ends with frame_done_o at N+16.
